dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache controller serving the MEM stage. Consumes MemRead/MemWrite, the ALU address and store data registered by the EX/MEM pipeline register. Returns load data to MEM/WB and drives the stall that feeds the pipeline registers' hold_i inputs. Talks to a line-wide backing memory with a req/ack handshake.

Parameters:
LINES, 32, number of cache lines (power of 2, ≥2)
LINE_BYTES, 32, bytes per line (fixed 8 words; line width 256 bits)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
MemRead_i  input  1  load request from EX/MEM
MemWrite_i  input  1  store request from EX/MEM
addr_i  input  32  byte address (ALU result), word aligned
wdata_i  input  32  store data
rdata_o  output  32  load data
stall_o  output  1  pipeline hold, drives hold_i of PC/IF_ID/ID_EX/EX_MEM/MEM_WB
mem_req_o  output  1  backing-memory request, held until ack
mem_we_o  output  1  1 = line write-back, 0 = line fill
mem_addr_o  output  32  line address, bits [4:0] = 0
mem_wdata_o  output  256  victim line data
mem_rdata_i  input  256  fill data, valid with mem_ack_i
mem_ack_i  input  1  one-cycle completion pulse

Behaviour:
- Address split: word = addr_i[4:2]; index = next log2(LINES) bits (addr_i[9:5] at default); tag = remaining upper bits (22 at default). addr_i[1:0] ignored.
- Per line: valid, dirty, tag, 256-bit data. Reset clears all valid and dirty bits; tag/data arrays are not reset.
- access = MemRead_i | MemWrite_i. Both set is treated as a store.
- hit = access & state==IDLE & valid[index] & tag match.
- stall_o = (state != IDLE) | (access & !hit). Combinational, asserted in the same cycle as the missing access.
- Read hit: rdata_o = selected word combinationally, zero added latency, stall_o=0. rdata_o = 0 whenever there is no read hit.
- Write hit: selected word replaced by wdata_i at the clock edge; dirty set. Other words are untouched.
- FSM states are IDLE, WRITEBACK, ALLOCATE.
  - IDLE to WRITEBACK: on a miss when the victim is valid & dirty.
  - IDLE to ALLOCATE: on a miss otherwise.
  - WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_wdata_o = victim line. On mem_ack_i, go to ALLOCATE.
  - ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, index, 5'b0}. On mem_ack_i, write mem_rdata_i into the line and set tag, valid=1, dirty=0, then go to IDLE.
  - Back in IDLE the still-held request hits, so stall_o drops that cycle and the access completes as a hit.
- Minimum miss penalty:
  - clean miss: 1 + (fill latency) cycles
  - dirty miss: adds the write-back latency
- mem_req_o and all mem_* outputs are stable from assertion until the ack cycle inclusive. mem_req_o deasserts the cycle after ack. Back-to-back write-back then fill keeps mem_req_o high with mem_we_o changing.
- mem_ack_i is ignored in IDLE.
- Inputs MemRead_i/MemWrite_i/addr_i/wdata_i are stable while stall_o=1; the pipeline hold guarantees this.
- Reset values: state=IDLE, all outputs 0 (stall_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0).
- Reset mid-transaction: state returns to IDLE immediately and mem_req_o drops asynchronously. The in-flight line is discarded; the backing memory tolerates an abandoned request.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WRITEBACK, ALLOCATE)
  - LINE_BITS=256, WORDS_PER_LINE=8
  - address field-width functions derived from LINES
- One sub-module, dcache_sram: tag/valid/dirty/data storage, with:
  - async-read ports
  - a word-write port (store hit)
  - a line-write port (fill)
- FSM, hit logic and muxing stay in dcache_ctrl.

Test Plan:
1. Reset low, then high; MemRead_i=1, addr_i=0x0000_0040 -> stall_o=1 same cycle; mem_req_o=1, mem_we_o=0, mem_addr_o=0x40. Ack with word1=0xDEADBEEF (mem_rdata_i[63:32]) -> stall_o=0 the next cycle. addr 0x44 then returns 0xDEADBEEF.
2. Store hit to 0x48 with 0x12345678 -> stall_o stays 0. Load 0x48 next cycle -> 0x12345678 with no stall.
3. Conflicting load to 0x0000_0448 (same index, new tag) after step 2 -> WRITEBACK with mem_we_o=1, mem_addr_o=0x40, mem_wdata_o word2=0x12345678. After ack: fill request mem_addr_o=0x440; after the second ack, load completes.
4. Clean conflict miss (reload 0x40 after a fill of 0x440 without stores) -> no write-back, only a fill request.
5. Assert reset while in ALLOCATE with mem_req_o=1 -> mem_req_o=0 and stall_o=0 immediately. Post-reset load of the same address misses again.
6. MemRead_i=MemWrite_i=0 with garbage addr_i and a stray mem_ack_i pulse -> stall_o=0, rdata_o=0, no state change.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field geometry for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LINE_BITS      = 256;
  localparam int unsigned WORDS_PER_LINE = 8;

  function automatic int unsigned offset_bits(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int unsigned index_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned lines, input int unsigned line_bytes);
    return ADDR_W - offset_bits(line_bytes) - index_bits(lines);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: async read, word write for store hits, line write for fills.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned LINES      = 32,
  parameter int unsigned LINE_BYTES = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [index_bits(LINES)-1:0]           rd_index,
  output logic                                   rd_valid,
  output logic                                   rd_dirty,
  output logic [tag_bits(LINES, LINE_BYTES)-1:0] rd_tag,
  output logic [LINE_BITS-1:0]                   rd_line,
  input  logic                                   ww_en,
  input  logic [index_bits(LINES)-1:0]           ww_index,
  input  logic [2:0]                             ww_word,
  input  logic [WORD_W-1:0]                      ww_data,
  input  logic                                   lw_en,
  input  logic [index_bits(LINES)-1:0]           lw_index,
  input  logic [tag_bits(LINES, LINE_BYTES)-1:0] lw_tag,
  input  logic [LINE_BITS-1:0]                   lw_data
);

  localparam int unsigned TAG_W = tag_bits(LINES, LINE_BYTES);

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (lw_en) begin
      valid_q[lw_index] <= 1'b1;
      dirty_q[lw_index] <= 1'b0;
    end else if (ww_en) begin
      dirty_q[ww_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (lw_en) begin
      tag_q[lw_index]  <= lw_tag;
      data_q[lw_index] <= lw_data;
    end else if (ww_en) begin
      data_q[ww_index][{ww_word, 5'b0} +: WORD_W] <= ww_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller for the MEM stage.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES      = 32,
  parameter int unsigned LINE_BYTES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic                 stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
);

  localparam int unsigned OFF_W = offset_bits(LINE_BYTES);
  localparam int unsigned IDX_W = index_bits(LINES);
  localparam int unsigned TAG_W = tag_bits(LINES, LINE_BYTES);

  state_t state_q, state_d;

  logic [2:0]           word;
  logic [IDX_W-1:0]     index;
  logic [TAG_W-1:0]     tag;
  logic                 rd_valid, rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 access, hit, miss;
  logic                 unused_addr_lsbs;

  assign word             = addr_i[OFF_W-1:2];
  assign index            = addr_i[OFF_W +: IDX_W];
  assign tag              = addr_i[ADDR_W-1 -: TAG_W];
  assign unused_addr_lsbs = ^addr_i[1:0];

  // Qualifying with reset keeps every output at zero while reset is held.
  assign access  = reset & (MemRead_i | MemWrite_i);
  assign hit     = access & (state_q == IDLE) & rd_valid & (rd_tag == tag);
  assign miss    = access & !hit;
  assign stall_o = reset & ((state_q != IDLE) | miss);
  assign rdata_o = (hit & !MemWrite_i) ? rd_line[{word, 5'b0} +: WORD_W] : '0;

  dcache_sram #(
    .LINES      (LINES),
    .LINE_BYTES (LINE_BYTES)
  ) u_sram (
    .clk      (clk),
    .reset    (reset),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .ww_en    (hit & MemWrite_i),
    .ww_index (index),
    .ww_word  (word),
    .ww_data  (wdata_i),
    .lw_en    ((state_q == ALLOCATE) & mem_ack_i),
    .lw_index (index),
    .lw_tag   (tag),
    .lw_data  (mem_rdata_i)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (miss) state_d = (rd_valid & rd_dirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {rd_tag, index, {OFF_W{1'b0}}};
        mem_wdata_o = rd_line;
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag, index, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: vector table for hit traffic, hand sequences for misses and reset.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         MemRead_i, MemWrite_i;
  logic [31:0]  addr_i, wdata_i, rdata_o;
  logic         stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o, mem_rdata_i;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(32), .LINE_BYTES(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  logic [255:0] line_a, victim;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h44, 32'h0,          1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 32'h4C, 32'h0,          1'b0, 1'b0, 32'hA0000003};
    vecs[2]  = '{1'b0, 1'b1, 32'h48, 32'h12345678,   1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h48, 32'h0,          1'b0, 1'b0, 32'h12345678};
    vecs[4]  = '{1'b1, 1'b0, 32'h44, 32'h0,          1'b0, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'h50, 32'h0,          1'b0, 1'b0, 32'hA0000004};
    vecs[6]  = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 32'h58, 32'hCAFEF00D,   1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h58, 32'h0,          1'b0, 1'b0, 32'hCAFEF00D};
    vecs[9]  = '{1'b1, 1'b0, 32'h5C, 32'h0,          1'b0, 1'b0, 32'hA0000007};
    vecs[10] = '{1'b1, 1'b0, 32'h40, 32'h0,          1'b0, 1'b0, 32'hA0000000};

    line_a = mk_line(32'hA0000000);
    line_a[63:32] = 32'hDEADBEEF;

    // Reset state
    reset = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rdata", rdata_o, 0);
    step(); step();
    reset = 1'b1;

    // Cold miss to 0x40, filled after one wait cycle
    MemRead_i = 1'b1; addr_i = 32'h40;
    #1;
    chk("cold_stall_same_cycle", stall_o, 1);
    chk("cold_req_idle", mem_req_o, 0);
    step();
    chk("fill1_req", mem_req_o, 1);
    chk("fill1_we", mem_we_o, 0);
    chk("fill1_addr", mem_addr_o, 32'h40);
    chk("fill1_stall", stall_o, 1);
    chk("fill1_rdata", rdata_o, 0);
    step();
    chk("fill1_hold_req", mem_req_o, 1);
    chk("fill1_hold_addr", mem_addr_o, 32'h40);
    mem_rdata_i = line_a; mem_ack_i = 1'b1;
    #1;
    chk("fill1_ack_cycle_req", mem_req_o, 1);
    step();
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    #1;
    chk("fill1_done_stall", stall_o, 0);
    chk("fill1_done_req", mem_req_o, 0);
    chk("fill1_done_rdata", rdata_o, 32'hA0000000);

    // Hit traffic, idle cycle with stray ack, store with both strobes set
    for (int i = 0; i < 11; i++) begin
      MemRead_i = vecs[i].rd; MemWrite_i = vecs[i].wr;
      addr_i = vecs[i].addr; wdata_i = vecs[i].wdata; mem_ack_i = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d_stall", i), stall_o, vecs[i].exp_stall);
      chk($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_req", i), mem_req_o, 0);
      step();
    end
    mem_ack_i = 1'b0; MemWrite_i = 1'b0; wdata_i = '0;

    // Dirty conflict miss: write-back of line 0x40, then fill of 0x440
    victim = line_a;
    victim[95:64]   = 32'h12345678;
    victim[223:192] = 32'hCAFEF00D;
    MemRead_i = 1'b1; addr_i = 32'h448;
    #1;
    chk("dirty_stall", stall_o, 1);
    chk("dirty_rdata", rdata_o, 0);
    step();
    chk("wb_req", mem_req_o, 1);
    chk("wb_we", mem_we_o, 1);
    chk("wb_addr", mem_addr_o, 32'h40);
    chk("wb_word2", mem_wdata_o[95:64], 32'h12345678);
    chk("wb_line", mem_wdata_o, victim);
    step();
    chk("wb_hold_addr", mem_addr_o, 32'h40);
    chk("wb_hold_line", mem_wdata_o, victim);
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("wb2fill_req", mem_req_o, 1);
    chk("wb2fill_we", mem_we_o, 0);
    chk("wb2fill_addr", mem_addr_o, 32'h440);
    chk("wb2fill_stall", stall_o, 1);
    mem_rdata_i = mk_line(32'hB0000000); mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("dirty_done_stall", stall_o, 0);
    chk("dirty_done_req", mem_req_o, 0);
    chk("dirty_done_rdata", rdata_o, 32'hB0000002);

    // Clean conflict miss back to 0x40: fill only
    addr_i = 32'h40;
    #1;
    chk("clean_stall", stall_o, 1);
    step();
    chk("clean_req", mem_req_o, 1);
    chk("clean_we", mem_we_o, 0);
    chk("clean_addr", mem_addr_o, 32'h40);
    mem_rdata_i = mk_line(32'hC0000000); mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("clean_done_stall", stall_o, 0);
    chk("clean_done_rdata", rdata_o, 32'hC0000000);

    // Reset asserted while a fill is outstanding
    addr_i = 32'h60;
    #1;
    chk("rstmid_miss_stall", stall_o, 1);
    step();
    chk("rstmid_req_before", mem_req_o, 1);
    chk("rstmid_addr_before", mem_addr_o, 32'h60);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_req_drop", mem_req_o, 0);
    chk("rstmid_stall_drop", stall_o, 0);
    chk("rstmid_rdata", rdata_o, 0);
    step();
    reset = 1'b1;
    #1;
    chk("post_rst_miss_stall", stall_o, 1);
    chk("post_rst_req_idle", mem_req_o, 0);
    step();
    chk("post_rst_fill_req", mem_req_o, 1);
    chk("post_rst_fill_addr", mem_addr_o, 32'h60);
    mem_rdata_i = mk_line(32'hD0000000); mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    #1;
    chk("post_rst_done_stall", stall_o, 0);
    chk("post_rst_done_rdata", rdata_o, 32'hD0000000);
    addr_i = 32'h40;
    #1;
    chk("post_rst_old_line_misses", stall_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
